// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage.
// Contents:
//   ALU_*  : width-independent ALU opcodes. The decoder uses the same set.
//   BR_*   : branch condition codes, selected by funct3.
//   MD_*   : RV-M operation codes, selected by funct3.
//   FWD_*  : forwarding-mux select encodings.
//   mdu_state_e : states of the iterative multiply/divide FSM.
//   md_a_signed / md_b_signed : report which operands an RV-M op treats as signed.
package exec_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_ZERO = 2'b11;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  function automatic logic md_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Iterative RV-M multiply/divide unit, one bit per cycle.
// Ports:
//   clk, rst (async active-low)
//   start  : begin an operation (honoured in IDLE only, and only when abort is low)
//   abort  : drop any operation in flight and return to IDLE
//   hold   : keep the result presented in DONE
//   op     : RV-M funct3
//   a, b   : operands, sampled at start
//   busy   : high while iterating
//   done   : high while the result is presented
//   result : selected result, valid while done is high
// Signed operations run on magnitudes; the signs are applied again at the output.
module mdu_iterative
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      op_q, op_d;
  logic            aneg_q, aneg_d, bneg_q, bneg_d, div0_q, div0_d;
  // m: multiplicand (mul) or divisor (div). hi: product high / partial remainder.
  // lo: multiplier shifting out and product low (mul), or dividend out / quotient in (div).
  logic [XLEN-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   add_sum, rem_sh, rem_diff;

  assign a_neg = md_a_signed(op) & a[XLEN-1];
  assign b_neg = md_b_signed(op) & b[XLEN-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  assign add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
  assign rem_sh   = {hi_q, lo_q[XLEN-1]};
  // Bit XLEN of the difference is set exactly when the trial subtract underflows.
  assign rem_diff = rem_sh - {1'b0, m_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    aneg_d  = aneg_q;
    bneg_d  = bneg_q;
    div0_d  = div0_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (abort) begin
      state_d = MDU_IDLE;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start) begin
            state_d = MDU_BUSY;
            count_d = '0;
            op_d    = op;
            aneg_d  = a_neg;
            bneg_d  = b_neg;
            div0_d  = (b == '0);
            hi_d    = '0;
            if (op[2]) begin
              m_d  = b_mag;
              lo_d = a_mag;
            end else begin
              m_d  = a_mag;
              lo_d = b_mag;
            end
          end
        end
        MDU_BUSY: begin
          if (op_q[2]) begin
            if (!rem_diff[XLEN]) begin
              hi_d = rem_diff[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = rem_sh[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = add_sum[XLEN:1];
            lo_d = {add_sum[0], lo_q[XLEN-1:1]};
          end
          count_d = count_q + 1'b1;
          if (count_q == CW'(XLEN-1)) state_d = MDU_DONE;
        end
        MDU_DONE: begin
          if (!hold) state_d = MDU_IDLE;
        end
        default: state_d = MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MDU_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    aneg_q <= aneg_d;
    bneg_q <= bneg_d;
    div0_q <= div0_d;
    m_q    <= m_d;
    hi_q   <= hi_d;
    lo_q   <= lo_d;
  end

  logic [2*XLEN-1:0] prod_raw, prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    prod_raw = {hi_q, lo_q};
    prod     = (aneg_q ^ bneg_q) ? (~prod_raw + 1'b1) : prod_raw;
    // Quotient by zero is all ones regardless of sign. The remainder needs no special
    // case: the magnitude of the dividend comes back with the dividend's sign.
    quo      = div0_q ? '1 : ((aneg_q ^ bneg_q) ? (~lo_q + 1'b1) : lo_q);
    rem      = aneg_q ? (~hi_q + 1'b1) : hi_q;
    case (op_q)
      MD_MUL:                       result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = quo;
      default:                      result = rem;
    endcase
  end

  assign busy = (state_q == MDU_BUSY);
  assign done = (state_q == MDU_DONE);

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage plus EX/MEM pipeline register.
// Ports:
//   clk, rst (async active-low), FlushE, StallM
//   decoded controls: RegWriteE, MemWriteE, ResultSelE, BranchE, JumpE, ALUSelE, MdOpE,
//     Funct3E, ALUControlE
//   operands: RegData1_E, RegData2_E, ImmExt_E, PCE, NextPCE, ResultData_W, RdE,
//     ForwardA_E, ForwardB_E
//   StallE                 : EX is busy with a multiply/divide
//   PCSrcE, PCTargetE      : combinational redirect
//   RegWriteM .. ALUResultM: EX/MEM register outputs
module execute_stage_md
  import exec_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REGW   = 5,
  parameter bit MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            FlushE,
  input  logic            StallM,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSelE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            ALUSelE,
  input  logic            MdOpE,
  input  logic [2:0]      Funct3E,
  input  logic [3:0]      ALUControlE,
  input  logic [XLEN-1:0] RegData1_E,
  input  logic [XLEN-1:0] RegData2_E,
  input  logic [XLEN-1:0] ImmExt_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] NextPCE,
  input  logic [XLEN-1:0] ResultData_W,
  input  logic [REGW-1:0] RdE,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  output logic            StallE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSelM,
  output logic [REGW-1:0] RdM,
  output logic [XLEN-1:0] NextPCM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALUResultM
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] src_a, src_bi, src_b, alu_res, md_res;
  logic [SHW-1:0]  shamt;
  logic            br_cond, md_sel;

  always_comb begin
    case (ForwardA_E)
      FWD_REG: src_a = RegData1_E;
      FWD_WB:  src_a = ResultData_W;
      FWD_MEM: src_a = ALUResultM;
      default: src_a = '0;
    endcase
    case (ForwardB_E)
      FWD_REG: src_bi = RegData2_E;
      FWD_WB:  src_bi = ResultData_W;
      FWD_MEM: src_bi = ALUResultM;
      default: src_bi = '0;
    endcase
  end

  assign src_b = ALUSelE ? ImmExt_E : src_bi;
  assign shamt = src_b[SHW-1:0];

  always_comb begin
    case (ALUControlE)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SLL:  alu_res = src_a << shamt;
      ALU_SRL:  alu_res = src_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  // Branches compare the register operands, never the immediate.
  always_comb begin
    case (Funct3E)
      BR_EQ:   br_cond = (src_a == src_bi);
      BR_NE:   br_cond = (src_a != src_bi);
      BR_LT:   br_cond = ($signed(src_a) < $signed(src_bi));
      BR_GE:   br_cond = ($signed(src_a) >= $signed(src_bi));
      BR_LTU:  br_cond = (src_a < src_bi);
      BR_GEU:  br_cond = (src_a >= src_bi);
      default: br_cond = 1'b0;
    endcase
  end

  assign PCTargetE = PCE + ImmExt_E;
  assign PCSrcE    = ~FlushE & (JumpE | (BranchE & br_cond));

  generate
    if (MDU_EN) begin : g_mdu
      logic md_busy, md_done;
      mdu_iterative #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (MdOpE),
        .abort  (FlushE),
        .hold   (StallM),
        .op     (Funct3E),
        .a      (src_a),
        .b      (src_bi),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_res)
      );
      // The start cycle stalls too; DONE releases EX so the result can be loaded.
      assign StallE = (~md_busy & ~md_done & MdOpE & ~FlushE) | md_busy;
      assign md_sel = MdOpE;
    end else begin : g_no_mdu
      assign md_res = '0;
      assign StallE = 1'b0;
      assign md_sel = 1'b0;
    end
  endgenerate

  logic            regwrite_q, regwrite_d, memwrite_q, memwrite_d, ressel_q, ressel_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic [XLEN-1:0] nextpc_q, nextpc_d, wdata_q, wdata_d, alures_q, alures_d;

  always_comb begin
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    ressel_d   = ressel_q;
    rd_d       = rd_q;
    nextpc_d   = nextpc_q;
    wdata_d    = wdata_q;
    alures_d   = alures_q;
    if (!StallM) begin
      if (FlushE || StallE) begin
        regwrite_d = 1'b0;
        memwrite_d = 1'b0;
        ressel_d   = 1'b0;
        rd_d       = '0;
        nextpc_d   = '0;
        wdata_d    = '0;
        alures_d   = '0;
      end else begin
        regwrite_d = RegWriteE;
        memwrite_d = MemWriteE;
        ressel_d   = ResultSelE;
        rd_d       = RdE;
        nextpc_d   = NextPCE;
        wdata_d    = src_bi;
        alures_d   = md_sel ? md_res : alu_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      ressel_q   <= 1'b0;
      rd_q       <= '0;
      nextpc_q   <= '0;
      wdata_q    <= '0;
      alures_q   <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      ressel_q   <= ressel_d;
      rd_q       <= rd_d;
      nextpc_q   <= nextpc_d;
      wdata_q    <= wdata_d;
      alures_q   <= alures_d;
    end
  end

  assign RegWriteM  = regwrite_q;
  assign MemWriteM  = memwrite_q;
  assign ResultSelM = ressel_q;
  assign RdM        = rd_q;
  assign NextPCM    = nextpc_q;
  assign WriteDataM = wdata_q;
  assign ALUResultM = alures_q;

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed bench for execute_stage_md: forwarding/ALU, branches, RV-M ops and their
// corner cases, StallM hold in DONE, flush and reset during an operation.
module tb_execute_stage_md;
  import exec_pkg::*;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            FlushE, StallM, RegWriteE, MemWriteE, ResultSelE, BranchE, JumpE, ALUSelE, MdOpE;
  logic [2:0]      Funct3E;
  logic [3:0]      ALUControlE;
  logic [XLEN-1:0] RegData1_E, RegData2_E, ImmExt_E, PCE, NextPCE, ResultData_W;
  logic [REGW-1:0] RdE;
  logic [1:0]      ForwardA_E, ForwardB_E;
  logic            StallE, PCSrcE, RegWriteM, MemWriteM, ResultSelM;
  logic [XLEN-1:0] PCTargetE, NextPCM, WriteDataM, ALUResultM;
  logic [REGW-1:0] RdM;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage_md #(.XLEN(XLEN), .REGW(REGW), .MDU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .FlushE(FlushE), .StallM(StallM),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSelE(ResultSelE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUSelE(ALUSelE), .MdOpE(MdOpE),
    .Funct3E(Funct3E), .ALUControlE(ALUControlE),
    .RegData1_E(RegData1_E), .RegData2_E(RegData2_E), .ImmExt_E(ImmExt_E),
    .PCE(PCE), .NextPCE(NextPCE), .ResultData_W(ResultData_W), .RdE(RdE),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSelM(ResultSelM),
    .RdM(RdM), .NextPCM(NextPCM), .WriteDataM(WriteDataM), .ALUResultM(ALUResultM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    FlushE = 0; StallM = 0; RegWriteE = 0; MemWriteE = 0; ResultSelE = 0;
    BranchE = 0; JumpE = 0; ALUSelE = 0; MdOpE = 0; Funct3E = 3'b000;
    ALUControlE = ALU_ADD; RegData1_E = '0; RegData2_E = '0; ImmExt_E = '0;
    PCE = '0; NextPCE = '0; ResultData_W = '0; RdE = '0;
    ForwardA_E = FWD_REG; ForwardB_E = FWD_REG;
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] imm, input logic [31:0] exp);
    ForwardA_E = FWD_REG; ForwardB_E = FWD_REG; ALUSelE = 1; ALUControlE = op;
    RegData1_E = a; ImmExt_E = imm; RegData2_E = 32'h0000DEAD; RegWriteE = 1; MdOpE = 0;
    step();
    chk(tag, ALUResultM, exp);
  endtask

  // Issues one RV-M op, counts stall cycles, then checks the loaded result.
  task automatic md_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int n;
    ForwardA_E = FWD_REG; ForwardB_E = FWD_REG; ALUSelE = 0; BranchE = 0; JumpE = 0;
    RegData1_E = a; RegData2_E = b; Funct3E = f3; MdOpE = 1; RegWriteE = 1; RdE = 5'd9;
    #1;
    n = 0;
    while (StallE === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk({tag, " stall cycles"}, 32'(n), 32'd33);
    chk({tag, " bubble"}, 32'(RegWriteM), 32'd0);
    step();
    MdOpE = 0; RegWriteE = 0;
    chk({tag, " result"}, ALUResultM, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clr_inputs();
    #2 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ALUResultM", ALUResultM, 32'd0);
    chk("rst RegWriteM", 32'(RegWriteM), 32'd0);
    chk("rst RdM", 32'(RdM), 32'd0);
    chk("rst WriteDataM", WriteDataM, 32'd0);
    chk("rst StallE", 32'(StallE), 32'd0);
    rst = 1;
    step();

    // Forwarding and the EX/MEM register
    RegData1_E = 2; RegData2_E = 3; ALUControlE = ALU_ADD; RegWriteE = 1; RdE = 5'd3;
    step();
    chk("add 2+3", ALUResultM, 32'd5);
    ForwardA_E = FWD_MEM; RegData1_E = 32'd999; RegData2_E = 7; RdE = 5'd4; NextPCE = 32'h44;
    step();
    chk("fwd mem add", ALUResultM, 32'd12);
    chk("fwd RegWriteM", 32'(RegWriteM), 32'd1);
    chk("fwd RdM", 32'(RdM), 32'd4);
    chk("fwd WriteDataM", WriteDataM, 32'd7);
    chk("fwd NextPCM", NextPCM, 32'h44);
    StallM = 1; RegData2_E = 100; RegWriteE = 0;
    step();
    chk("StallM hold ALUResultM", ALUResultM, 32'd12);
    chk("StallM hold RegWriteM", 32'(RegWriteM), 32'd1);
    StallM = 0;
    step();
    chk("after hold 12+100", ALUResultM, 32'd112);
    chk("after hold RegWriteM", 32'(RegWriteM), 32'd0);
    ForwardA_E = FWD_REG; RegData1_E = 32'h10; ForwardB_E = FWD_WB; ResultData_W = 32'h5;
    RegData2_E = 32'h999; ALUControlE = ALU_SUB;
    step();
    chk("fwd wb sub", ALUResultM, 32'hB);
    chk("fwd wb WriteDataM", WriteDataM, 32'h5);

    // ALU operations through the immediate path
    alu_vec("alu and",  ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
    alu_vec("alu or",   ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0);
    alu_vec("alu xor",  ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
    alu_vec("alu slt",  ALU_SLT,  32'hFFFFFFFF, 32'h1, 32'h1);
    alu_vec("alu sltu", ALU_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0);
    alu_vec("alu sll",  ALU_SLL,  32'h1, 32'h24, 32'h10);
    alu_vec("alu srl",  ALU_SRL,  32'h80000000, 32'h4, 32'h08000000);
    alu_vec("alu sra",  ALU_SRA,  32'h80000000, 32'h4, 32'hF8000000);
    alu_vec("alu sub wrap", ALU_SUB, 32'd5, 32'd7, 32'hFFFFFFFE);
    alu_vec("alu code12", 4'd12, 32'h1234, 32'h5678, 32'h0);
    ForwardA_E = FWD_ZERO; ALUControlE = ALU_ADD; RegData1_E = 32'h55; ImmExt_E = 32'd7;
    step();
    chk("fwd zero add", ALUResultM, 32'd7);

    // Branches and jumps
    clr_inputs();
    RegData1_E = 32'hFFFFFFFF; RegData2_E = 32'h1; BranchE = 1; PCE = 32'h100;
    ImmExt_E = 32'h20; ALUSelE = 1; Funct3E = BR_LT;
    #1;
    chk("blt taken", 32'(PCSrcE), 32'd1);
    chk("PCTargetE", PCTargetE, 32'h120);
    Funct3E = BR_LTU; #1;
    chk("bltu not taken", 32'(PCSrcE), 32'd0);
    Funct3E = BR_LT; FlushE = 1; #1;
    chk("blt flushed", 32'(PCSrcE), 32'd0);
    FlushE = 0;
    step();
    Funct3E = BR_GE; #1;
    chk("bge not taken", 32'(PCSrcE), 32'd0);
    Funct3E = BR_GEU; #1;
    chk("bgeu taken", 32'(PCSrcE), 32'd1);
    Funct3E = BR_NE; #1;
    chk("bne taken", 32'(PCSrcE), 32'd1);
    step();
    RegData2_E = 32'hFFFFFFFF; Funct3E = BR_EQ; #1;
    chk("beq taken", 32'(PCSrcE), 32'd1);
    Funct3E = 3'b010; #1;
    chk("funct3 010 never", 32'(PCSrcE), 32'd0);
    BranchE = 0; JumpE = 1; #1;
    chk("jump", 32'(PCSrcE), 32'd1);
    step();
    clr_inputs();

    // RV-M operations and corner cases
    md_op("div 100/-7",   MD_DIV,    32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2);
    md_op("rem 100/-7",   MD_REM,    32'd100, 32'hFFFFFFF9, 32'd2);
    md_op("rem -100/7",   MD_REM,    32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE);
    md_op("divu 100/7",   MD_DIVU,   32'd100, 32'd7, 32'd14);
    md_op("div -100/0",   MD_DIV,    32'hFFFFFF9C, 32'd0, 32'hFFFFFFFF);
    md_op("rem -100/0",   MD_REM,    32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C);
    md_op("remu x/0",     MD_REMU,   32'h1234, 32'd0, 32'h1234);
    md_op("div ovf",      MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    md_op("rem ovf",      MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0);
    md_op("mulhu",        MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    md_op("mul",          MD_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);
    md_op("mulh -1*-1",   MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
    md_op("mulh -2*3",    MD_MULH,   32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
    md_op("mulhsu",       MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // StallM held while the MDU sits in DONE
    RegData1_E = 32'hFFFFFFFF; RegData2_E = 32'hFFFFFFFF; Funct3E = MD_MULHU;
    MdOpE = 1; RegWriteE = 1; RdE = 5'd7;
    #1;
    n = 0;
    while (StallE === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("done-hold stall cycles", 32'(n), 32'd33);
    StallM = 1;
    repeat (3) begin
      step();
      chk("done-hold StallE", 32'(StallE), 32'd0);
      chk("done-hold ALUResultM", ALUResultM, 32'd0);
    end
    StallM = 0;
    step();
    chk("done-hold release", ALUResultM, 32'hFFFFFFFE);
    chk("done-hold RdM", 32'(RdM), 32'd7);
    MdOpE = 0; ALUControlE = ALU_ADD; RegData1_E = 1; RegData2_E = 2; #1;
    chk("no restart StallE", 32'(StallE), 32'd0);
    step();
    chk("add after md", ALUResultM, 32'd3);

    // Flush during BUSY
    RegData1_E = 32'd100; RegData2_E = 32'd7; Funct3E = MD_DIV; MdOpE = 1; RdE = 5'd8;
    repeat (10) step();
    chk("busy before flush", 32'(StallE), 32'd1);
    FlushE = 1;
    step();
    FlushE = 0; MdOpE = 0; RegData1_E = 1; RegData2_E = 2; ALUControlE = ALU_ADD;
    RegWriteE = 1; RdE = 5'd6; #1;
    chk("flush StallE", 32'(StallE), 32'd0);
    chk("flush RegWriteM", 32'(RegWriteM), 32'd0);
    step();
    chk("post-flush add", ALUResultM, 32'd3);
    chk("post-flush RegWriteM", 32'(RegWriteM), 32'd1);
    chk("post-flush RdM", 32'(RdM), 32'd6);

    // Reset during BUSY
    RegData1_E = 32'd100; RegData2_E = 32'd7; Funct3E = MD_DIVU; MdOpE = 1; StallM = 1;
    repeat (5) step();
    chk("busy hold ALUResultM", ALUResultM, 32'd3);
    #2 rst = 0; MdOpE = 0; StallM = 0;
    #1;
    chk("mid rst ALUResultM", ALUResultM, 32'd0);
    chk("mid rst RegWriteM", 32'(RegWriteM), 32'd0);
    chk("mid rst RdM", 32'(RdM), 32'd0);
    chk("mid rst StallE", 32'(StallE), 32'd0);
    rst = 1;
    step();
    md_op("post-rst divu", MD_DIVU, 32'd100, 32'd7, 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
